// File: rtl/stopwatch_timer.sv
// stopwatch_timer
//   MM:SS stopwatch with a generic clock divider. Counts up or down at
//   TICK_HZ, supports a preload while stopped, a lap capture register,
//   clear, a one-cycle wrap pulse (up count) and a one-cycle expiry pulse
//   (down count). All outputs come straight from flops.
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   start, stop           level run / halt requests (start wins a tie)
//   clear                 zero time, lap and divider; halt
//   load, load_sec/min    preload time, accepted only while stopped
//   mode                  0 = up, 1 = down; latched into dir on start
//   lap                   capture current time into lap_sec/lap_min
//   sec, min              current time
//   lap_sec, lap_min      captured time; lap_valid marks a capture
//   running, dir          run state and latched direction
//   expired, wrapped      one-cycle event pulses
module stopwatch_timer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int MIN_W   = 7,
  parameter int MIN_MAX = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             load,
  input  logic [5:0]       load_sec,
  input  logic [MIN_W-1:0] load_min,
  input  logic             mode,
  input  logic             lap,
  output logic [5:0]       sec,
  output logic [MIN_W-1:0] min,
  output logic [5:0]       lap_sec,
  output logic [MIN_W-1:0] lap_min,
  output logic             lap_valid,
  output logic             running,
  output logic             dir,
  output logic             expired,
  output logic             wrapped
);

  // state  | meaning
  // S_IDLE | halted; divider frozen, preload accepted
  // S_RUN  | counting; divider advances every cycle

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MIN_MAX);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic             at_zero, at_one, at_top;
  logic             start_ok, expire_now, wrap_now;

  assign tick       = (state == S_RUN) && (div == DIV_LAST);
  assign at_zero    = (sec == 6'd0) && (min == '0);
  assign at_one     = (sec == 6'd1) && (min == '0);
  assign at_top     = (sec == 6'd59) && (min == MIN_LAST);
  assign expire_now = tick && dir && at_one;
  assign wrap_now   = tick && !dir && at_top;
  // A down count from 00:00 would expire immediately, so refuse to start it.
  assign start_ok   = start && !(mode && at_zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        // load outranks start, so a same-cycle start is dropped
        S_IDLE: if (!load && start_ok) state_nxt = S_RUN;
        S_RUN:  if (expire_now || (stop && !start)) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    running = (state == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec       <= '0;
      min       <= '0;
      div       <= '0;
      lap_sec   <= '0;
      lap_min   <= '0;
      lap_valid <= 1'b0;
      dir       <= 1'b0;
      expired   <= 1'b0;
      wrapped   <= 1'b0;
    end else begin
      expired <= 1'b0;
      wrapped <= 1'b0;
      if (clear) begin
        sec       <= '0;
        min       <= '0;
        div       <= '0;
        lap_sec   <= '0;
        lap_min   <= '0;
        lap_valid <= 1'b0;
      end else begin
        // Captures the value before any tick on this edge.
        if (lap) begin
          lap_sec   <= sec;
          lap_min   <= min;
          lap_valid <= 1'b1;
        end
        if (state == S_RUN) begin
          div <= tick ? '0 : div + 1'b1;
          if (tick) begin
            expired <= expire_now;
            wrapped <= wrap_now;
            if (!dir) begin
              if (sec == 6'd59) begin
                sec <= '0;
                min <= (min == MIN_LAST) ? '0 : min + 1'b1;
              end else begin
                sec <= sec + 1'b1;
              end
            end else begin
              if (sec == 6'd0) begin
                sec <= 6'd59;
                min <= min - 1'b1;
              end else begin
                sec <= sec - 1'b1;
              end
            end
          end
        end else if (load) begin
          sec <= (load_sec > 6'd59) ? 6'd59 : load_sec;
          min <= (load_min > MIN_LAST) ? MIN_LAST : load_min;
          div <= '0;
        end else if (start_ok) begin
          dir <= mode;
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_timer.sv
// tb_stopwatch_timer
//   Scoreboarded bench for stopwatch_timer with CLK_HZ=10, TICK_HZ=1.
//   The reference model keeps time as a plain count of seconds and the
//   divider as a count of elapsed running cycles.
module tb_stopwatch_timer;
  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int MIN_W   = 7;
  localparam int MIN_MAX = 99;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int SPAN    = (MIN_MAX + 1) * 60;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
  logic             mode = 1'b0, lap = 1'b0;
  logic [5:0]       load_sec = '0;
  logic [MIN_W-1:0] load_min = '0;
  logic [5:0]       sec, lap_sec;
  logic [MIN_W-1:0] min, lap_min;
  logic             lap_valid, running, dir, expired, wrapped;

  stopwatch_timer #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MIN_W(MIN_W), .MIN_MAX(MIN_MAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_sec(load_sec), .load_min(load_min), .mode(mode),
    .lap(lap), .sec(sec), .min(min), .lap_sec(lap_sec), .lap_min(lap_min),
    .lap_valid(lap_valid), .running(running), .dir(dir),
    .expired(expired), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]       sec;
    logic [MIN_W-1:0] min;
    logic [5:0]       lap_sec;
    logic [MIN_W-1:0] lap_min;
    logic             lap_valid;
    logic             running;
    logic             dir;
    logic             expired;
    logic             wrapped;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_exp, mon_act;
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model
  int m_t, m_frac, m_lap_t;
  bit m_run, m_dir, m_lapv, m_exp, m_wrap;

  function automatic int clip(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_t = 0; m_frac = 0; m_lap_t = 0;
    m_run = 0; m_dir = 0; m_lapv = 0; m_exp = 0; m_wrap = 0;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.sec       = 6'(m_t % 60);
    o.min       = MIN_W'(m_t / 60);
    o.lap_sec   = 6'(m_lap_t % 60);
    o.lap_min   = MIN_W'(m_lap_t / 60);
    o.lap_valid = m_lapv;
    o.running   = m_run;
    o.dir       = m_dir;
    o.expired   = m_exp;
    o.wrapped   = m_wrap;
    return o;
  endfunction

  // One clock edge of behaviour, from the inputs currently applied.
  task automatic model_step();
    bit expire_evt;
    m_exp = 0; m_wrap = 0; expire_evt = 0;
    if (rst) begin
      model_reset();
    end else if (clear) begin
      m_t = 0; m_frac = 0; m_lap_t = 0; m_lapv = 0; m_run = 0;
    end else begin
      if (lap) begin
        m_lap_t = m_t; m_lapv = 1;
      end
      if (m_run) begin
        m_frac = m_frac + 1;
        if (m_frac == DIV) begin
          m_frac = 0;
          if (!m_dir) begin
            m_t = (m_t + 1) % SPAN;
            if (m_t == 0) m_wrap = 1;
          end else begin
            m_t = m_t - 1;
            if (m_t == 0) begin
              expire_evt = 1; m_exp = 1;
            end
          end
        end
        if (expire_evt || (stop && !start)) m_run = 0;
      end else if (load) begin
        m_t = clip(int'(load_sec), 59) + 60 * clip(int'(load_min), MIN_MAX);
        m_frac = 0;
      end else if (start && !(mode && m_t == 0)) begin
        m_run = 1; m_dir = mode;
      end
    end
  endtask

  task automatic step();
    model_step();
    exp_q.push_back(model_obs());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; clear = 0; load = 0; lap = 0;
  endtask

  task automatic check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // monitor: every edge with a pending expectation is compared
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {sec, min, lap_sec, lap_min, lap_valid, running, dir, expired, wrapped};
      n_checks++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL scoreboard at %0t: got %h, expected %h", $time, mon_act, mon_exp);
      end
    end
  end

  initial begin
    model_reset();
    #1 rst = 1;
    repeat (2) @(negedge clk);
    check("reset_sec", int'(sec), 0);
    check("reset_min", int'(min), 0);
    check("reset_running", int'(running), 0);
    check("reset_lap_valid", int'(lap_valid), 0);
    check("reset_pulses", int'({dir, expired, wrapped}), 0);
    rst = 0;

    // up count: 600 clocks = one minute
    start = 1; mode = 0; step(); idle_inputs();
    steps(600);
    check("up_sec", int'(sec), 0);
    check("up_min", int'(min), 1);
    check("up_running", int'(running), 1);
    check("up_wrapped", int'(wrapped), 0);

    // wrap at 99:59 -> 00:00
    stop = 1; step(); idle_inputs();
    load = 1; load_sec = 58; load_min = 99; step(); idle_inputs();
    check("load_sec", int'(sec), 58);
    check("load_min", int'(min), 99);
    start = 1; mode = 0; step(); idle_inputs();
    steps(19);
    check("prewrap_sec", int'(sec), 59);
    check("prewrap_wrapped", int'(wrapped), 0);
    step();
    check("wrap_time", int'({min, sec}), 0);
    check("wrap_pulse", int'(wrapped), 1);
    step();
    check("wrap_pulse_end", int'(wrapped), 0);
    check("wrap_running", int'(running), 1);

    // down count from 01:00
    stop = 1; step(); idle_inputs();
    load = 1; load_sec = 0; load_min = 1; step(); idle_inputs();
    start = 1; mode = 1; step(); idle_inputs();
    steps(10);
    check("down_sec", int'(sec), 59);
    check("down_min", int'(min), 0);
    check("down_dir", int'(dir), 1);
    steps(589);
    check("down_last_sec", int'(sec), 1);
    check("down_no_expire", int'(expired), 0);
    step();
    check("expire_sec", int'(sec), 0);
    check("expire_running", int'(running), 0);
    check("expire_pulse", int'(expired), 1);
    step();
    check("expire_pulse_end", int'(expired), 0);
    start = 1; mode = 1; step(); idle_inputs();
    check("start_at_zero_ignored", int'(running), 0);

    // pause keeps the divider fraction
    clear = 1; step(); idle_inputs();
    start = 1; mode = 0; step(); idle_inputs();
    steps(24);
    stop = 1; step(); idle_inputs();
    steps(39);
    check("pause_sec", int'(sec), 2);
    check("pause_running", int'(running), 0);
    start = 1; step(); idle_inputs();
    steps(5);
    check("resume_sec", int'(sec), 3);

    // lap on the tick cycle at 00:04
    clear = 1; step(); idle_inputs();
    start = 1; mode = 0; step(); idle_inputs();
    steps(49);
    lap = 1; step(); idle_inputs();
    check("lap_sec", int'(lap_sec), 4);
    check("lap_live_sec", int'(sec), 5);
    check("lap_valid", int'(lap_valid), 1);
    clear = 1; step(); idle_inputs();
    check("clear_time", int'({min, sec}), 0);
    check("clear_lap", int'({lap_min, lap_sec, lap_valid}), 0);
    check("clear_running", int'(running), 0);

    // load while running is ignored; async reset mid-count
    start = 1; step(); idle_inputs();
    steps(15);
    load = 1; load_sec = 30; load_min = 30; step(); idle_inputs();
    check("load_running_sec", int'(sec), 1);
    check("load_running_min", int'(min), 0);
    steps(3);
    #2 rst = 1;
    #1;
    check("async_rst_time", int'({min, sec}), 0);
    check("async_rst_flags", int'({running, dir, lap_valid}), 0);
    model_reset();
    @(negedge clk);
    step();
    rst = 0;
    steps(20);
    check("post_rst_running", int'(running), 0);
    check("post_rst_sec", int'(sec), 0);

    // randomized phase, biased toward boundary preloads
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 399) == 0);
      clear = ($urandom_range(0, 99) == 0);
      load  = ($urandom_range(0, 15) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      lap   = ($urandom_range(0, 7) == 0);
      mode  = 1'($urandom_range(0, 1));
      load_sec = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(55, 63))
                                             : 6'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       load_min = MIN_W'($urandom_range(97, 127));
        1:       load_min = MIN_W'($urandom_range(0, 1));
        default: load_min = MIN_W'($urandom_range(0, 127));
      endcase
      step();
    end
    rst = 0; idle_inputs();
    step();
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
